multicaster: RTL and testbench

MULTICASTER -- requirements
Module: multicaster

---
 rtl/multicaster_pkg.sv | 21 ++
 rtl/mc_fifo.sv | 69 ++++++
 rtl/multicaster.sv | 201 ++++++++++++++++++++
 tb/tb_multicaster.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicaster_pkg.sv
// Shared definitions for the multicaster: FSM states, stream indices and
// the psum width helper used by the top and its buffers.
package multicaster_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } mc_state_t;

    localparam int IFMAP       = 0;
    localparam int FLTR        = 1;
    localparam int PSUM        = 2;
    localparam int NUM_STREAMS = 3;

    // Partial sums carry twice the operand width.
    function automatic int psum_width(input int data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/mc_fifo.sv
// Small circular buffer with a combinational head.
// DEPTH must be a power of two, so the pointers wrap on their own.
module mc_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against the current fill level so overflow and
    // underflow can never corrupt the pointers.
    always_comb begin
        do_push_s = push && (count_r != CW'(DEPTH));
        do_pop_s  = pop && (count_r != {CW{1'b0}});
    end

    // Storage, pointers and occupancy; soft reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (srst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/multicaster.sv
// Column multicaster: captures bus words tagged for this column into three
// operand buffers, issues operand triples to the PE, and returns PE results
// to the bus through a return buffer sized to bound outstanding work.
module multicaster
    import multicaster_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_COL    = 4,
    parameter  int FIFO_DEPTH = 2,
    localparam int IDW        = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
    localparam int PW         = psum_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDW-1:0]        ID,
    input  logic [IDW-1:0]        TAG,
    input  logic [2:0]            CASTER_EN,
    input  logic [DATA_WIDTH-1:0] ifmap_data_B2M,
    input  logic [DATA_WIDTH-1:0] fltr_data_B2M,
    input  logic [PW-1:0]         psum_data_B2M,
    output logic                  CASTER_READY,
    output logic                  CASTER_VALID,
    input  logic                  psum_ack,
    output logic [DATA_WIDTH-1:0] ifmap_data_M2B,
    output logic [DATA_WIDTH-1:0] fltr_data_M2B,
    output logic [PW-1:0]         psum_data_M2B,
    output logic [DATA_WIDTH-1:0] ifmap_data_M2P,
    output logic [DATA_WIDTH-1:0] fltr_data_M2P,
    output logic [PW-1:0]         psum_data_M2P,
    output logic                  PE_EN,
    input  logic                  PE_READY,
    input  logic [PW-1:0]         psum_data_P2M,
    input  logic                  PE_VALID,
    input  logic [7:0]            cfg_kernel_size,
    output logic [7:0]            kernel_size,
    input  logic                  flush,
    output logic                  err_unexp
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    mc_state_t             state_r;
    mc_state_t             state_next_s;
    logic [2:0]            sel_s;
    logic [2:0]            acc_s;
    logic [2:0]            full_s;
    logic [2:0]            empty_s;
    logic                  ready_s;
    logic                  issue_ok_s;
    logic                  pe_en_s;
    logic                  issue_s;
    logic                  pe_expected_s;
    logic                  pe_unexp_s;
    logic                  ret_push_s;
    logic                  ret_pop_s;
    logic                  ret_empty_s;
    logic                  caster_valid_s;
    logic                  clear_s;
    logic                  all_empty_s;
    logic [CW-1:0]         ret_count_s;
    logic [OW-1:0]         occupancy_s;
    logic [CW-1:0]         in_flight_r;
    logic [CW-1:0]         in_flight_next_s;
    logic [DATA_WIDTH-1:0] ifmap_m2b_r;
    logic [DATA_WIDTH-1:0] fltr_m2b_r;
    logic [7:0]            kernel_size_r;
    logic                  err_unexp_r;
    logic [CW-1:0]         unused_ifmap_cnt_s;
    logic [CW-1:0]         unused_fltr_cnt_s;
    logic [CW-1:0]         unused_psum_cnt_s;
    logic                  unused_ret_full_s;

    // Bus acceptance, issue qualification and result-return handshakes.
    // Outstanding work (in flight plus waiting results) is capped at the
    // return buffer depth so every PE result is guaranteed a slot.
    always_comb begin
        sel_s          = CASTER_EN & {3{TAG == ID}};
        ready_s        = (state_r != ST_FLUSH) && ((CASTER_EN & full_s) == 3'b000);
        acc_s          = sel_s & {3{ready_s}};
        occupancy_s    = {1'b0, in_flight_r} + {1'b0, ret_count_s};
        issue_ok_s     = (empty_s == 3'b000) && (occupancy_s < OW'(FIFO_DEPTH));
        pe_en_s        = (state_r == ST_ACTIVE) && issue_ok_s;
        issue_s        = pe_en_s && PE_READY;
        pe_expected_s  = PE_VALID && (in_flight_r != {CW{1'b0}});
        pe_unexp_s     = PE_VALID && (in_flight_r == {CW{1'b0}});
        ret_push_s     = pe_expected_s && (state_r != ST_FLUSH);
        caster_valid_s = !ret_empty_s && (state_r != ST_FLUSH);
        ret_pop_s      = psum_ack && caster_valid_s;
        clear_s        = (state_r == ST_FLUSH);
        all_empty_s    = (empty_s == 3'b111) && ret_empty_s;
    end

    // Outstanding-operation count; issue and return together cancel out.
    always_comb begin
        case ({issue_s, pe_expected_s})
            2'b10:   in_flight_next_s = in_flight_r + 1'b1;
            2'b01:   in_flight_next_s = in_flight_r - 1'b1;
            default: in_flight_next_s = in_flight_r;
        endcase
    end

    // Next-state logic; flush overrides every state.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = ST_FLUSH;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (acc_s != 3'b000) begin
                        state_next_s = ST_ACTIVE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    // Stay active if a word lands this cycle, or it would
                    // be stranded in IDLE where nothing issues.
                    if (all_empty_s && (in_flight_r == {CW{1'b0}}) && (acc_s == 3'b000)) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_ACTIVE;
                    end
                end
                ST_FLUSH: begin
                    if (in_flight_next_s == {CW{1'b0}}) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_FLUSH;
                    end
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // State, in-flight count, bus echo registers, kernel size and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            in_flight_r   <= {CW{1'b0}};
            ifmap_m2b_r   <= {DATA_WIDTH{1'b0}};
            fltr_m2b_r    <= {DATA_WIDTH{1'b0}};
            kernel_size_r <= 8'd0;
            err_unexp_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_flight_r <= in_flight_next_s;
            if (acc_s[IFMAP]) begin
                ifmap_m2b_r <= ifmap_data_B2M;
            end
            if (acc_s[FLTR]) begin
                fltr_m2b_r <= fltr_data_B2M;
            end
            if (state_r == ST_IDLE) begin
                kernel_size_r <= cfg_kernel_size;
            end
            if (pe_unexp_s) begin
                err_unexp_r <= 1'b1;
            end
        end
    end

    mc_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_ifmap_fifo (
        .clk(clk), .rst_n(rst_n), .srst(clear_s),
        .push(acc_s[IFMAP]), .pop(issue_s), .wdata(ifmap_data_B2M),
        .rdata(ifmap_data_M2P), .full(full_s[IFMAP]), .empty(empty_s[IFMAP]),
        .count(unused_ifmap_cnt_s)
    );

    mc_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fltr_fifo (
        .clk(clk), .rst_n(rst_n), .srst(clear_s),
        .push(acc_s[FLTR]), .pop(issue_s), .wdata(fltr_data_B2M),
        .rdata(fltr_data_M2P), .full(full_s[FLTR]), .empty(empty_s[FLTR]),
        .count(unused_fltr_cnt_s)
    );

    mc_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH)) u_psum_fifo (
        .clk(clk), .rst_n(rst_n), .srst(clear_s),
        .push(acc_s[PSUM]), .pop(issue_s), .wdata(psum_data_B2M),
        .rdata(psum_data_M2P), .full(full_s[PSUM]), .empty(empty_s[PSUM]),
        .count(unused_psum_cnt_s)
    );

    mc_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH)) u_ret_fifo (
        .clk(clk), .rst_n(rst_n), .srst(clear_s),
        .push(ret_push_s), .pop(ret_pop_s), .wdata(psum_data_P2M),
        .rdata(psum_data_M2B), .full(unused_ret_full_s), .empty(ret_empty_s),
        .count(ret_count_s)
    );

    assign CASTER_READY   = ready_s;
    assign CASTER_VALID   = caster_valid_s;
    assign PE_EN          = pe_en_s;
    assign ifmap_data_M2B = ifmap_m2b_r;
    assign fltr_data_M2B  = fltr_m2b_r;
    assign kernel_size    = kernel_size_r;
    assign err_unexp      = err_unexp_r;

endmodule

// File: tb/tb_multicaster.sv
// Bench for the multicaster: a table of single-operation vectors followed by
// hand-built sequences for backpressure, flush and reset. Expected PE results
// go into a scoreboard queue when stimulus is driven and are popped when the
// DUT presents them on psum_data_M2B.
module tb_multicaster;

    localparam int DW  = 16;
    localparam int PW  = 32;
    localparam int IDW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IDW-1:0] ID, TAG;
    logic [2:0]    CASTER_EN;
    logic [DW-1:0] ifmap_data_B2M, fltr_data_B2M;
    logic [PW-1:0] psum_data_B2M;
    logic          CASTER_READY, CASTER_VALID, psum_ack;
    logic [DW-1:0] ifmap_data_M2B, fltr_data_M2B;
    logic [PW-1:0] psum_data_M2B;
    logic [DW-1:0] ifmap_data_M2P, fltr_data_M2P;
    logic [PW-1:0] psum_data_M2P;
    logic          PE_EN, PE_READY, PE_VALID;
    logic [PW-1:0] psum_data_P2M;
    logic [7:0]    cfg_kernel_size, kernel_size;
    logic          flush, err_unexp;

    multicaster #(.DATA_WIDTH(DW), .NUM_COL(4), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .ID(ID), .TAG(TAG), .CASTER_EN(CASTER_EN),
        .ifmap_data_B2M(ifmap_data_B2M), .fltr_data_B2M(fltr_data_B2M),
        .psum_data_B2M(psum_data_B2M), .CASTER_READY(CASTER_READY),
        .CASTER_VALID(CASTER_VALID), .psum_ack(psum_ack),
        .ifmap_data_M2B(ifmap_data_M2B), .fltr_data_M2B(fltr_data_M2B),
        .psum_data_M2B(psum_data_M2B), .ifmap_data_M2P(ifmap_data_M2P),
        .fltr_data_M2P(fltr_data_M2P), .psum_data_M2P(psum_data_M2P),
        .PE_EN(PE_EN), .PE_READY(PE_READY), .psum_data_P2M(psum_data_P2M),
        .PE_VALID(PE_VALID), .cfg_kernel_size(cfg_kernel_size),
        .kernel_size(kernel_size), .flush(flush), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] ifm;
        logic [DW-1:0] flt;
        logic [PW-1:0] ps;
        logic [PW-1:0] res;
    } vec_t;

    vec_t          vecs [5];
    logic [PW-1:0] exp_q [$];
    int            total = 0;
    int            bad   = 0;
    logic [PW-1:0] pe_res;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic chk_ret(input string name);
        logic [PW-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %0h expected <empty scoreboard>", name, psum_data_M2B);
        end else begin
            e = exp_q.pop_front();
            chk(name, {32'd0, psum_data_M2B}, {32'd0, e});
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] en, input logic [DW-1:0] i, input logic [DW-1:0] f,
                          input logic [PW-1:0] p);
        CASTER_EN      = en;
        ifmap_data_B2M = i;
        fltr_data_B2M  = f;
        psum_data_B2M  = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{16'd3,      16'd4,      32'd10,         32'd22};
        vecs[1] = '{16'd0,      16'd0,      32'd0,          32'd0};
        vecs[2] = '{16'hFFFF,   16'hFFFF,   32'd0,          32'hFFFE0001};
        vecs[3] = '{16'd2,      16'd3,      32'hFFFFFFFF,   32'd5};
        vecs[4] = '{16'd100,    16'd200,    32'd7,          32'd20007};

        rst_n = 1'b0; ID = 2'd2; TAG = 2'd2; set_in(3'b000, 16'd0, 16'd0, 32'd0);
        psum_ack = 1'b0; PE_READY = 1'b0; PE_VALID = 1'b0; psum_data_P2M = 32'd0;
        cfg_kernel_size = 8'd7; flush = 1'b0;
        #2;
        chk("rst_pe_en", PE_EN, 1'b0);
        chk("rst_caster_valid", CASTER_VALID, 1'b0);
        chk("rst_ifmap_m2b", ifmap_data_M2B, 16'd0);
        chk("rst_kernel", kernel_size, 8'd0);
        chk("rst_err", err_unexp, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick;
        chk("kernel_load_idle", kernel_size, 8'd7);

        // Table-driven single operations through the full path.
        for (int k = 0; k < 5; k++) begin
            set_in(3'b111, vecs[k].ifm, vecs[k].flt, vecs[k].ps);
            #1;
            chk("v_ready", CASTER_READY, 1'b1);
            exp_q.push_back(vecs[k].res);
            tick;
            set_in(3'b000, 16'd0, 16'd0, 32'd0);
            #1;
            chk("v_m2b_ifmap", ifmap_data_M2B, vecs[k].ifm);
            chk("v_m2b_fltr", fltr_data_M2B, vecs[k].flt);
            chk("v_pe_en", PE_EN, 1'b1);
            chk("v_m2p_ifmap", ifmap_data_M2P, vecs[k].ifm);
            chk("v_m2p_fltr", fltr_data_M2P, vecs[k].flt);
            chk("v_m2p_psum", psum_data_M2P, vecs[k].ps);
            pe_res = PW'(ifmap_data_M2P) * PW'(fltr_data_M2P) + psum_data_M2P;
            PE_READY = 1'b1;
            tick;
            PE_READY = 1'b0;
            #1;
            chk("v_pe_en_done", PE_EN, 1'b0);
            PE_VALID = 1'b1; psum_data_P2M = pe_res;
            tick;
            PE_VALID = 1'b0;
            #1;
            chk("v_caster_valid", CASTER_VALID, 1'b1);
            chk_ret("v_psum_m2b");
            psum_ack = 1'b1;
            tick;
            psum_ack = 1'b0;
            #1;
            chk("v_valid_after_ack", CASTER_VALID, 1'b0);
        end

        // Foreign tag: nothing captured, ready still high.
        TAG = 2'd1;
        set_in(3'b111, 16'd55, 16'd66, 32'd77);
        #1;
        chk("tag_ready", CASTER_READY, 1'b1);
        tick;
        set_in(3'b000, 16'd0, 16'd0, 32'd0);
        #1;
        chk("tag_pe_en", PE_EN, 1'b0);
        chk("tag_m2b_hold", ifmap_data_M2B, 16'd100);
        chk("tag_valid", CASTER_VALID, 1'b0);
        TAG = 2'd2;
        tick;

        // Ifmap buffer fills with the PE stalled; third word waits for a pop.
        set_in(3'b001, 16'd1, 16'd0, 32'd0);
        #1; chk("fill_ready1", CASTER_READY, 1'b1);
        tick;
        cfg_kernel_size = 8'd9;
        set_in(3'b001, 16'd2, 16'd0, 32'd0);
        #1; chk("fill_ready2", CASTER_READY, 1'b1);
        tick;
        set_in(3'b001, 16'd3, 16'd0, 32'd0);
        #1; chk("fill_blocked", CASTER_READY, 1'b0);
        tick;
        #1; chk("fill_m2b_hold", ifmap_data_M2B, 16'd2);
        chk("kernel_hold_active", kernel_size, 8'd7);
        set_in(3'b110, 16'd0, 16'd5, 32'd7); tick;
        set_in(3'b110, 16'd0, 16'd6, 32'd8); tick;
        set_in(3'b001, 16'd3, 16'd0, 32'd0);
        #1;
        chk("fill_pe_en", PE_EN, 1'b1);
        chk("fill_still_blocked", CASTER_READY, 1'b0);
        chk("fill_m2p_ifmap", ifmap_data_M2P, 16'd1);
        chk("fill_m2p_fltr", fltr_data_M2P, 16'd5);
        chk("fill_m2p_psum", psum_data_M2P, 32'd7);
        exp_q.push_back(32'd12);
        exp_q.push_back(32'd20);
        PE_READY = 1'b1;
        tick;
        #1;
        chk("pop_frees_ready", CASTER_READY, 1'b1);
        chk("second_issue_en", PE_EN, 1'b1);
        tick;
        PE_READY = 1'b0;
        set_in(3'b000, 16'd0, 16'd0, 32'd0);
        #1;
        chk("third_accepted", ifmap_data_M2B, 16'd3);
        chk("no_fltr_no_issue", PE_EN, 1'b0);

        // Two unacknowledged results block issue even with full inputs.
        PE_VALID = 1'b1; psum_data_P2M = 32'd12; tick;
        psum_data_P2M = 32'd20; tick;
        PE_VALID = 1'b0;
        #1; chk("ret_valid", CASTER_VALID, 1'b1);
        set_in(3'b111, 16'd4, 16'd9, 32'd1); tick;
        set_in(3'b110, 16'd0, 16'd10, 32'd2); tick;
        set_in(3'b111, 16'd0, 16'd0, 32'd0);
        #1;
        chk("full_inputs_ready", CASTER_READY, 1'b0);
        set_in(3'b000, 16'd0, 16'd0, 32'd0);
        #1;
        chk("ret_full_blocks_issue", PE_EN, 1'b0);
        chk_ret("ret_first");
        psum_ack = 1'b1; tick; psum_ack = 1'b0;
        #1;
        chk("ack_reissue", PE_EN, 1'b1);
        chk_ret("ret_second");
        chk("reissue_m2p_ifmap", ifmap_data_M2P, 16'd3);
        chk("reissue_m2p_fltr", fltr_data_M2P, 16'd9);
        chk("reissue_m2p_psum", psum_data_M2P, 32'd1);
        exp_q.push_back(32'd28);
        PE_READY = 1'b1; tick; PE_READY = 1'b0;
        #1; chk("occupancy_limit", PE_EN, 1'b0);

        // Flush with one operation still in the PE.
        flush = 1'b1; tick; flush = 1'b0;
        #1;
        chk("flush_ready", CASTER_READY, 1'b0);
        chk("flush_valid", CASTER_VALID, 1'b0);
        chk("flush_pe_en", PE_EN, 1'b0);
        PE_VALID = 1'b1; psum_data_P2M = 32'd28; tick; PE_VALID = 1'b0;
        exp_q.delete();
        #1;
        chk("flush_late_discard", CASTER_VALID, 1'b0);
        chk("flush_no_err", err_unexp, 1'b0);
        chk("flush_idle_ready", CASTER_READY, 1'b1);
        set_in(3'b111, 16'd0, 16'd0, 32'd0);
        #1; chk("flush_cleared_fifos", CASTER_READY, 1'b1);
        set_in(3'b000, 16'd0, 16'd0, 32'd0);

        // Result with nothing outstanding is dropped and flagged.
        PE_VALID = 1'b1; psum_data_P2M = 32'd99; tick; PE_VALID = 1'b0;
        #1;
        chk("unexp_err", err_unexp, 1'b1);
        chk("unexp_discard", CASTER_VALID, 1'b0);
        chk("kernel_reload_idle", kernel_size, 8'd9);
        tick;
        chk("unexp_sticky", err_unexp, 1'b1);

        // Reset in the middle of traffic.
        set_in(3'b111, 16'd5, 16'd6, 32'd1); tick;
        set_in(3'b000, 16'd0, 16'd0, 32'd0);
        PE_READY = 1'b1; tick; PE_READY = 1'b0;
        set_in(3'b111, 16'd7, 16'd7, 32'd7); tick;
        set_in(3'b000, 16'd0, 16'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pe_en", PE_EN, 1'b0);
        chk("mid_rst_valid", CASTER_VALID, 1'b0);
        chk("mid_rst_ifmap_m2b", ifmap_data_M2B, 16'd0);
        chk("mid_rst_fltr_m2b", fltr_data_M2B, 16'd0);
        chk("mid_rst_m2p", ifmap_data_M2P, 16'd0);
        chk("mid_rst_psum_m2b", psum_data_M2B, 32'd0);
        chk("mid_rst_kernel", kernel_size, 8'd0);
        chk("mid_rst_err", err_unexp, 1'b0);
        #1 rst_n = 1'b1;
        set_in(3'b111, 16'd11, 16'd2, 32'd9);
        exp_q.push_back(32'd31);
        tick;
        set_in(3'b000, 16'd0, 16'd0, 32'd0);
        #1;
        chk("post_rst_accept", ifmap_data_M2B, 16'd11);
        chk("post_rst_pe_en", PE_EN, 1'b1);
        PE_READY = 1'b1; tick; PE_READY = 1'b0;
        PE_VALID = 1'b1; psum_data_P2M = 32'd31; tick; PE_VALID = 1'b0;
        #1;
        chk("post_rst_valid", CASTER_VALID, 1'b1);
        chk_ret("post_rst_psum");
        chk("post_rst_no_err", err_unexp, 1'b0);
        psum_ack = 1'b1; tick; psum_ack = 1'b0;
        #1;
        chk("post_rst_drained", CASTER_VALID, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
